vpu_cmd_sched: RTL and testbench
================================

// Module: vpu_cmd_sched
// PURPOSE
//  Host-side command scheduler for the VPU matrix unit. Buffers geometry commands
//  (create/delete/translate/rotate/scale) from the host in a FIFO. Issues them one at
//  a time over the matrix unit's go/busy handshake, holding operands stable for the
//  whole operation. Sits between the host interface and matrix_unit, in vpu_top, in
//  place of the hard-coded instruction sequencer.
// PARAMETERS
//  DEPTH    8   command FIFO entries (power of 2, >=2)
//  AW       3   log2(DEPTH)
//  TIMEOUT  64  cycles to wait for busy after go (used only with CMD_TIMEOUT_EN)
// PORTS
//  clk          in   1    system clock (clkgen CLK0_OUT)
//  rst_n        in   1    asynchronous active-low reset
//  cmd_vld      in   1    host command valid
//  cmd_rdy      out  1    FIFO can accept; push = cmd_vld & cmd_rdy
//  cmd_op       in   4    gmt_op encoding
//  cmd_code     in   4    gmt_code (axis/point/angle/scale)
//  cmd_type     in   2    obj type for create (1 line, 2 tri, 3 quad)
//  cmd_color    in   8    obj color for create
//  cmd_num      in   5    target object number
//  cmd_vtx      in   128  {v7..v0}, 8 x signed 16b vertex operands
//  go           out  1    one-cycle issue strobe to matrix_unit
//  gmt_op       out  4    registered operands to matrix_unit; stable from go until
//  gmt_code     out  4      busy falls
//  obj_type     out  2
//  obj_color    out  8
//  obj_num      out  5
//  vtx          out  128
//  busy         in   1    matrix_unit busy
//  obj_mem_full in   1    object memory full (from matrix_unit)
//  fifo_cnt     out  AW+1 entries held
//  idle         out  1    FIFO empty and FSM in IDLE
//  done         out  1    one-cycle pulse when an issued command completes
//  err_sts      out  3    sticky {timeout, bad_op, mem_full_drop}
//  err_clr      in   1    clears err_sts (set wins on same cycle)
// BEHAVIOUR
//  Reset values: all outputs 0 except idle=1 and cmd_rdy=1. FIFO empty, FSM in IDLE.
//  FIFO: show-ahead. cmd_rdy = (fifo_cnt != DEPTH). Push and pop in the same cycle keep
//   fifo_cnt unchanged. Pointers wrap modulo DEPTH.
//  FSM: IDLE -> LOAD -> ISSUE -> WAIT_ACK -> WAIT_DONE -> IDLE.
//   IDLE: if FIFO is non-empty, go to LOAD.
//   LOAD (cycle N): latch the head into the operand registers and pop it. Then validate:
//    - op not in {0,1,3,4,6,7,8}: set err_sts[1], drop the command, go to IDLE.
//    - op=0 and obj_mem_full=1: set err_sts[0], drop the command, go to IDLE.
//    - otherwise go to ISSUE.
//   ISSUE (N+1): go=1 for exactly one cycle, then WAIT_ACK.
//   WAIT_ACK: stay until busy=1, then WAIT_DONE.
//   WAIT_DONE: stay until busy=0, then pulse done and return to IDLE.
//  Minimum spacing between go strobes: 5 cycles. Operands never change while busy=1.
//  Dropped commands do not pulse done.
//  Asynchronous reset mid-operation drops go immediately and empties the FIFO. The
//   matrix_unit is reset by the same rst_n.
// CONFIGURATION
//  CMD_TIMEOUT_EN defined: WAIT_ACK counts cycles. If busy is still 0 after TIMEOUT
//   cycles, set err_sts[2] and return to IDLE with no done pulse.
//  Not defined: WAIT_ACK waits indefinitely, there is no counter, and err_sts[2] is
//   tied to 0.
// STRUCTURE
//  vpu_pkg: gmt_op localparams (OP_CRT=0, OP_DEL=1, OP_TR1=3, OP_TR=4, OP_ROTL=6,
//   OP_ROTR=7, OP_SCL=8), FSM state encodings, command word width (CMD_W=151).
//  Sub-module vpu_cmd_fifo: DEPTH x CMD_W show-ahead FIFO with count, full and empty.
// TESTING
//  1 Reset, push create quad (op0,type3) -> go at cycle 2 after push with obj_type=3;
//    busy 1 for 10 cycles -> done one cycle after busy falls; idle=1.
//  2 Push 9 commands with busy held high -> cmd_rdy=0 after the 8th; fifo_cnt=8.
//    Release busy -> commands issue in push order, one done each.
//  3 Push op=5 -> no go, err_sts=3'b010. Pulse err_clr -> err_sts=0.
//  4 obj_mem_full=1 with create queued -> dropped, err_sts[0]=1. A following
//    delete(num=1) still issues.
//  5 CMD_TIMEOUT_EN, TIMEOUT=64, busy stuck 0 after go -> err_sts[2] set 64 cycles
//    later; next command issues.
//  6 Deassert rst_n while in WAIT_DONE -> go=0, fifo_cnt=0, idle=1 with no clock edge.

Source files
------------

// File: rtl/vpu_pkg.sv
// vpu_pkg: opcodes, FSM state encodings and command word layout for the VPU command scheduler
package vpu_pkg;
   localparam logic [3:0] OP_CRT  = 4'd0;
   localparam logic [3:0] OP_DEL  = 4'd1;
   localparam logic [3:0] OP_TR1  = 4'd3;
   localparam logic [3:0] OP_TR   = 4'd4;
   localparam logic [3:0] OP_ROTL = 4'd6;
   localparam logic [3:0] OP_ROTR = 4'd7;
   localparam logic [3:0] OP_SCL  = 4'd8;
   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_LOAD      = 3'd1;
   localparam logic [2:0] ST_ISSUE     = 3'd2;
   localparam logic [2:0] ST_WAIT_ACK  = 3'd3;
   localparam logic [2:0] ST_WAIT_DONE = 3'd4;
   localparam int CMD_W = 151;
   typedef struct packed {
      logic [3:0]   op;
      logic [3:0]   code;
      logic [1:0]   typ;
      logic [7:0]   color;
      logic [4:0]   num;
      logic [127:0] vtx;
   } cmd_t;
   function automatic logic op_ok(input logic [3:0] op);
      return op inside {OP_CRT, OP_DEL, OP_TR1, OP_TR, OP_ROTL, OP_ROTR, OP_SCL};
   endfunction
endpackage

// File: rtl/vpu_cmd_sched_if.sv
// vpu_cmd_sched_if: host command channel (valid/ready plus command fields)
interface vpu_cmd_sched_if;
   logic         cmd_vld;
   logic         cmd_rdy;
   logic [3:0]   cmd_op;
   logic [3:0]   cmd_code;
   logic [1:0]   cmd_type;
   logic [7:0]   cmd_color;
   logic [4:0]   cmd_num;
   logic [127:0] cmd_vtx;
   modport master (output cmd_vld, cmd_op, cmd_code, cmd_type, cmd_color, cmd_num, cmd_vtx,
                   input cmd_rdy);
   modport slave (input cmd_vld, cmd_op, cmd_code, cmd_type, cmd_color, cmd_num, cmd_vtx,
                  output cmd_rdy);
endinterface

// File: rtl/vpu_cmd_fifo.sv
// vpu_cmd_fifo: show-ahead command FIFO with occupancy count, full and empty
module vpu_cmd_fifo import vpu_pkg::*; #(
   parameter int DEPTH = 8,
   parameter int AW    = 3,
   parameter int W     = CMD_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic [AW:0]   cnt,
   output logic          full,
   output logic          empty
);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic          wr, rd;
   assign full  = cnt == (AW+1)'(DEPTH);
   assign empty = cnt == '0;
   assign wr    = push & ~full;
   assign rd    = pop & ~empty;
   assign dout  = mem[rp];
   // pointers wrap naturally at DEPTH; simultaneous push and pop leave cnt unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         wp  <= wr ? wp + 1'b1 : wp;
         rp  <= rd ? rp + 1'b1 : rp;
         cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
      end
   end
   // storage needs no reset: empty FIFO contents are never observed
   always_ff @(posedge clk) begin
      if (wr) mem[wp] <= din;
   end
endmodule

// File: rtl/vpu_cmd_sched.sv
// vpu_cmd_sched: buffers host geometry commands and issues them one at a time to matrix_unit
// Optional build macro CMD_TIMEOUT_EN adds a busy-acknowledge watchdog in WAIT_ACK.
module vpu_cmd_sched import vpu_pkg::*; #(
   parameter int DEPTH   = 8,
   parameter int AW      = 3,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   vpu_cmd_sched_if.slave      cif,
   output logic                go,
   output logic [3:0]          gmt_op,
   output logic [3:0]          gmt_code,
   output logic [1:0]          obj_type,
   output logic [7:0]          obj_color,
   output logic [4:0]          obj_num,
   output logic [127:0]        vtx,
   input  logic                busy,
   input  logic                obj_mem_full,
   output logic [AW:0]         fifo_cnt,
   output logic                idle,
   output logic                done,
   output logic [2:0]          err_sts,
   input  logic                err_clr
);
   logic [2:0] state, nxt;
   cmd_t       head, cur, din;
   logic       full, empty, pop, bad_op, drop_full, tmo;
   assign din         = {cif.cmd_op, cif.cmd_code, cif.cmd_type, cif.cmd_color, cif.cmd_num, cif.cmd_vtx};
   assign cif.cmd_rdy = ~full;
   vpu_cmd_fifo #(.DEPTH(DEPTH), .AW(AW), .W(CMD_W)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (cif.cmd_vld),
      .pop   (pop),
      .din   (din),
      .dout  (head),
      .cnt   (fifo_cnt),
      .full  (full),
      .empty (empty)
   );
   assign pop       = state == ST_LOAD;
   assign bad_op    = ~op_ok(head.op);
   assign drop_full = head.op == OP_CRT && obj_mem_full;
   assign go        = state == ST_ISSUE;
   assign idle      = empty && state == ST_IDLE;
   assign {gmt_op, gmt_code, obj_type, obj_color, obj_num, vtx} = cur;
   // next-state: LOAD validates the head; WAIT_ACK/WAIT_DONE follow matrix_unit busy
   always_comb begin
      nxt = state;
      case (state)
         ST_IDLE:      nxt = empty ? ST_IDLE : ST_LOAD;
         ST_LOAD:      nxt = (bad_op || drop_full) ? ST_IDLE : ST_ISSUE;
         ST_ISSUE:     nxt = ST_WAIT_ACK;
         ST_WAIT_ACK:  nxt = busy ? ST_WAIT_DONE : tmo ? ST_IDLE : ST_WAIT_ACK;
         ST_WAIT_DONE: nxt = busy ? ST_WAIT_DONE : ST_IDLE;
         default:      nxt = ST_IDLE;
      endcase
   end
   // state, operand hold, completion pulse and sticky errors (a new error beats err_clr)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         cur     <= '0;
         done    <= 1'b0;
         err_sts <= 3'b000;
      end else begin
         state   <= nxt;
         cur     <= pop ? head : cur;
         done    <= state == ST_WAIT_DONE && !busy;
         err_sts <= (err_clr ? 3'b000 : err_sts) | {tmo, pop && bad_op, pop && drop_full};
      end
   end
`ifdef CMD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] tcnt;
   assign tmo = state == ST_WAIT_ACK && !busy && tcnt == TW'(TIMEOUT - 1);
   // cycles spent waiting for busy; restarts on every entry to WAIT_ACK
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) tcnt <= '0;
      else        tcnt <= state == ST_WAIT_ACK ? tcnt + 1'b1 : '0;
   end
`else
   logic unused_timeout;
   assign tmo            = 1'b0;
   assign unused_timeout = ^TIMEOUT;
`endif
endmodule

// File: tb/tb_vpu_cmd_sched.sv
// tb_vpu_cmd_sched: table-driven and scoreboard checks of the VPU command scheduler
module tb_vpu_cmd_sched;
   import vpu_pkg::*;
   logic         clk = 0, rst_n = 1, busy = 0, obj_mem_full = 0, err_clr = 0;
   logic         go, idle, done;
   logic [3:0]   gmt_op, gmt_code, fifo_cnt;
   logic [1:0]   obj_type;
   logic [7:0]   obj_color;
   logic [4:0]   obj_num;
   logic [127:0] vtx;
   logic [2:0]   err_sts;
   cmd_t         cur_out, snap;
   cmd_t         sb[$];
   int           n_chk = 0, n_fail = 0, n_go = 0, n_done = 0, cyc = 0, last_go = -100;
   bit           model_en = 1, hold = 0;
   int           busy_len = 3;

   typedef struct {
      logic [3:0] op;
      logic [3:0] code;
      logic [1:0] typ;
      logic [4:0] num;
      bit         mf;
      logic [2:0] err;
   } vec_t;
   vec_t v[13];

   vpu_cmd_sched_if cif();
   vpu_cmd_sched #(.DEPTH(8), .AW(3), .TIMEOUT(64)) dut (
      .clk(clk), .rst_n(rst_n), .cif(cif), .go(go), .gmt_op(gmt_op), .gmt_code(gmt_code),
      .obj_type(obj_type), .obj_color(obj_color), .obj_num(obj_num), .vtx(vtx), .busy(busy),
      .obj_mem_full(obj_mem_full), .fifo_cnt(fifo_cnt), .idle(idle), .done(done),
      .err_sts(err_sts), .err_clr(err_clr)
   );
   assign cur_out = {gmt_op, gmt_code, obj_type, obj_color, obj_num, vtx};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_i(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_c(input string name, input cmd_t act, input cmd_t exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // scoreboard: every go pops the oldest expected command; operands must hold while busy
   always @(negedge clk) begin
      if (rst_n) begin
         if (go) begin
            n_go++;
            if (sb.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL go_unexpected: got go with op %0d, expected no issue", gmt_op);
            end else chk_c("operands", cur_out, sb.pop_front());
            chk_i("go_spacing_ge5", int'(cyc - last_go >= 5), 1);
            last_go = cyc;
            snap = cur_out;
         end
         if (busy) chk_c("operands_stable", cur_out, snap);
         if (done) n_done++;
      end
   end

   // matrix_unit model: busy rises the cycle after go, holds busy_len cycles (longer while hold)
   initial forever begin
      @(negedge clk);
      if (go && model_en && rst_n) begin
         @(posedge clk);
         #1 busy = 1;
         repeat (busy_len) @(posedge clk);
         while (hold) @(posedge clk);
         #1 busy = 0;
      end
   end

   task automatic push(input cmd_t c, input bit exp_go, output bit acc);
      @(negedge clk);
      {cif.cmd_op, cif.cmd_code, cif.cmd_type, cif.cmd_color, cif.cmd_num, cif.cmd_vtx} = c;
      cif.cmd_vld = 1;
      acc = cif.cmd_rdy;
      if (acc && exp_go) sb.push_back(c);
      @(posedge clk);
      #1 cif.cmd_vld = 0;
   endtask

   task automatic wait_idle(input int bound);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(idle && !busy) && k < bound);
      if (!(idle && !busy)) begin
         n_chk++;
         n_fail++;
         $display("FAIL idle_timeout: idle=%0d busy=%0d after %0d cycles", idle, busy, bound);
      end
      @(negedge clk);
   endtask

   task automatic wait_sig(input string name, input bit want_busy, input int bound);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(want_busy ? busy : go) && k < bound);
      if (!(want_busy ? busy : go)) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: not seen within %0d cycles", name, bound);
      end
   endtask

   task automatic clear_err();
      @(negedge clk);
      err_clr = 1;
      @(negedge clk);
      err_clr = 0;
   endtask

   function automatic cmd_t mk(input logic [3:0] op, input logic [3:0] code, input logic [1:0] typ,
                               input logic [7:0] color, input logic [4:0] num);
      return '{op: op, code: code, typ: typ, color: color, num: num,
               vtx: {$urandom, $urandom, $urandom, $urandom}};
   endfunction

   initial begin
      bit acc;
      int d0, g0;
      cmd_t c;
      v[0]  = '{4'd0, 4'd0, 2'd3, 5'd2,  1'b0, 3'b000};
      v[1]  = '{4'd1, 4'd0, 2'd0, 5'd1,  1'b0, 3'b000};
      v[2]  = '{4'd3, 4'd2, 2'd0, 5'd3,  1'b0, 3'b000};
      v[3]  = '{4'd4, 4'd5, 2'd0, 5'd4,  1'b0, 3'b000};
      v[4]  = '{4'd6, 4'd1, 2'd0, 5'd5,  1'b0, 3'b000};
      v[5]  = '{4'd7, 4'd9, 2'd0, 5'd6,  1'b0, 3'b000};
      v[6]  = '{4'd8, 4'd3, 2'd0, 5'd31, 1'b0, 3'b000};
      v[7]  = '{4'd5, 4'd0, 2'd0, 5'd7,  1'b0, 3'b010};
      v[8]  = '{4'd2, 4'd0, 2'd0, 5'd8,  1'b0, 3'b010};
      v[9]  = '{4'd15, 4'd0, 2'd0, 5'd9, 1'b0, 3'b010};
      v[10] = '{4'd0, 4'd0, 2'd2, 5'd10, 1'b1, 3'b001};
      v[11] = '{4'd1, 4'd0, 2'd0, 5'd11, 1'b1, 3'b000};
      v[12] = '{4'd9, 4'd0, 2'd0, 5'd12, 1'b1, 3'b010};
      cif.cmd_vld = 0;
      {cif.cmd_op, cif.cmd_code, cif.cmd_type, cif.cmd_color, cif.cmd_num, cif.cmd_vtx} = '0;
      #1 rst_n = 0;
      repeat (3) @(negedge clk);
      chk_i("rst_go", int'(go), 0);
      chk_i("rst_idle", int'(idle), 1);
      chk_i("rst_cmd_rdy", int'(cif.cmd_rdy), 1);
      chk_i("rst_fifo_cnt", int'(fifo_cnt), 0);
      chk_i("rst_done", int'(done), 0);
      chk_i("rst_err", int'(err_sts), 0);
      chk_c("rst_operands", cur_out, '0);
      rst_n = 1;

      // create quad: go two cycles after the push edge, done one cycle after busy falls
      busy_len = 10;
      c = mk(4'd0, 4'd0, 2'd3, 8'h5a, 5'd1);
      push(c, 1, acc);
      @(negedge clk);
      chk_i("t1_go_e0", int'(go), 0);
      @(negedge clk);
      chk_i("t1_go_e1", int'(go), 0);
      @(negedge clk);
      chk_i("t1_go_e2", int'(go), 1);
      chk_i("t1_obj_type", int'(obj_type), 3);
      wait_sig("t1_busy", 1, 10);
      begin
         int k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (busy && k < 30);
      end
      chk_i("t1_done_early", int'(done), 0);
      @(negedge clk);
      chk_i("t1_done", int'(done), 1);
      chk_i("t1_idle", int'(idle), 1);
      @(negedge clk);
      chk_i("t1_done_one_cycle", int'(done), 0);

      // table of single commands covering every legal op, bad ops and mem-full drops
      busy_len = 3;
      for (int i = 0; i < 13; i++) begin
         clear_err();
         obj_mem_full = v[i].mf;
         c = mk(v[i].op, v[i].code, v[i].typ, 8'(i * 17), v[i].num);
         d0 = n_done;
         g0 = n_go;
         push(c, v[i].err == 3'b000, acc);
         wait_idle(60);
         chk_i($sformatf("vec%0d_err", i), int'(err_sts), int'(v[i].err));
         chk_i($sformatf("vec%0d_done", i), n_done - d0, int'(v[i].err == 3'b000));
         chk_i($sformatf("vec%0d_go", i), n_go - g0, int'(v[i].err == 3'b000));
         obj_mem_full = 0;
      end

      // fill the FIFO while matrix_unit is held busy, then drain in order
      clear_err();
      busy_len = 2;
      hold = 1;
      push(mk(4'd4, 4'd1, 2'd0, 8'h11, 5'd0), 1, acc);
      wait_sig("t2_busy", 1, 10);
      d0 = n_done;
      for (int k = 0; k < 8; k++) begin
         push(mk(4'(k == 2 ? 8 : k == 5 ? 6 : 1), 4'(k), 2'd0, 8'(k), 5'(k + 1)), 1, acc);
         chk_i($sformatf("t2_acc%0d", k), int'(acc), 1);
      end
      @(negedge clk);
      chk_i("t2_full_rdy", int'(cif.cmd_rdy), 0);
      chk_i("t2_full_cnt", int'(fifo_cnt), 8);
      push(mk(4'd1, 4'd0, 2'd0, 8'hff, 5'd30), 1, acc);
      chk_i("t2_ninth_rejected", int'(acc), 0);
      chk_i("t2_cnt_hold", int'(fifo_cnt), 8);
      hold = 0;
      wait_idle(200);
      chk_i("t2_dones", n_done - d0, 9);
      chk_i("t2_sb_empty", sb.size(), 0);

      // bad op while err_clr is held: the set beats the clear, then the clear takes over
      err_clr = 1;
      push(mk(4'd5, 4'd0, 2'd0, 8'h0, 5'd0), 0, acc);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk_i("t3_set_wins", int'(err_sts), 3'b010);
      @(negedge clk);
      chk_i("t3_cleared", int'(err_sts), 0);
      err_clr = 0;

      // create dropped on mem-full, following delete still issues
      obj_mem_full = 1;
      d0 = n_done;
      push(mk(4'd0, 4'd0, 2'd1, 8'h33, 5'd2), 0, acc);
      push(mk(4'd1, 4'd0, 2'd0, 8'h00, 5'd1), 1, acc);
      wait_idle(60);
      obj_mem_full = 0;
      chk_i("t4_err", int'(err_sts), 3'b001);
      chk_i("t4_done", n_done - d0, 1);

`ifdef CMD_TIMEOUT_EN
      // busy never answers: watchdog fires 64 cycles after WAIT_ACK entry
      clear_err();
      model_en = 0;
      d0 = n_done;
      push(mk(4'd1, 4'd0, 2'd0, 8'h00, 5'd3), 1, acc);
      wait_sig("t5_go", 0, 10);
      @(posedge clk);
      repeat (63) @(posedge clk);
      @(negedge clk);
      chk_i("t5_not_yet", int'(err_sts[2]), 0);
      @(negedge clk);
      chk_i("t5_timeout", int'(err_sts[2]), 1);
      chk_i("t5_no_done", n_done - d0, 0);
      model_en = 1;
      push(mk(4'd3, 4'd0, 2'd0, 8'h00, 5'd4), 1, acc);
      wait_idle(60);
      chk_i("t5_next_done", n_done - d0, 1);
`endif

      // asynchronous reset while waiting for busy to fall
      hold = 1;
      push(mk(4'd7, 4'd2, 2'd0, 8'h44, 5'd5), 1, acc);
      wait_sig("t6_busy", 1, 10);
      push(mk(4'd1, 4'd0, 2'd0, 8'h00, 5'd6), 0, acc);
      push(mk(4'd1, 4'd0, 2'd0, 8'h00, 5'd7), 0, acc);
      @(negedge clk);
      #2 rst_n = 0;
      #1;
      chk_i("t6_go", int'(go), 0);
      chk_i("t6_fifo_cnt", int'(fifo_cnt), 0);
      chk_i("t6_idle", int'(idle), 1);
      chk_c("t6_operands", cur_out, '0);
      hold = 0;
      busy = 0;
      sb.delete();
      @(negedge clk);
      rst_n = 1;

      // asynchronous reset while go is high drops it at once
      model_en = 0;
      push(mk(4'd1, 4'd0, 2'd0, 8'h00, 5'd8), 1, acc);
      wait_sig("t6b_go", 0, 10);
      #2 rst_n = 0;
      #1;
      chk_i("t6b_go_drop", int'(go), 0);
      chk_i("t6b_idle", int'(idle), 1);
      sb.delete();
      @(negedge clk);
      rst_n = 1;
      model_en = 1;

      d0 = n_done;
      push(mk(4'd6, 4'd4, 2'd0, 8'h00, 5'd9), 1, acc);
      wait_idle(60);
      chk_i("post_rst_done", n_done - d0, 1);
      chk_i("final_sb_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
